// File: rtl/team_07_pkg.sv
// Shared button indices, codes and helpers for the team_07 button conditioner.
package team_07_pkg;

   localparam int NUM_BUTTONS = 6;

   localparam int BTN_SELECT = 0;
   localparam int BTN_UP     = 1;
   localparam int BTN_RIGHT  = 2;
   localparam int BTN_DOWN   = 3;
   localparam int BTN_LEFT   = 4;
   localparam int BTN_BACK   = 5;

   typedef enum logic [2:0] {
      CODE_NONE   = 3'd0,
      CODE_SELECT = 3'd1,
      CODE_UP     = 3'd2,
      CODE_RIGHT  = 3'd3,
      CODE_DOWN   = 3'd4,
      CODE_LEFT   = 3'd5,
      CODE_BACK   = 3'd6
   } button_code_t;

   // Lowest set index wins; code is index + 1.
   function automatic button_code_t first_code(
      input logic [NUM_BUTTONS-1:0] v
   );
      button_code_t c;
      c = CODE_NONE;
      for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
         if (v[i]) c = button_code_t'(3'(i + 1));
      end
      return c;
   endfunction

endpackage

// File: rtl/team_07_debounce.sv
// One-bit conditioner: two-flop synchroniser, stability counter, debounced level.
module team_07_debounce
   import team_07_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 10000
) (
   input  logic clk,
   input  logic nrst,
   input  logic en,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;
   logic          differ;
   logic          done;

   assign differ = sync2 ^ level;
   assign done   = differ & (cnt == CW'(DEBOUNCE_CYCLES - 1));
   assign rise   = en & done & ~level;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Disabled: level forced low so a held button re-qualifies as a new press.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (!en) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (!differ) begin
         cnt <= '0;
      end else if (done) begin
         cnt   <= '0;
         level <= ~level;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/team_07_button_conditioner.sv
// Six-button sync/debounce with fixed-priority press strobe and code.
// Optional auto-repeat of the held button under `BUTTON_AUTOREPEAT_EN.
module team_07_button_conditioner
   import team_07_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 10000,
   parameter int REPEAT_DELAY    = 20000000,
   parameter int REPEAT_PERIOD   = 4000000
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic                   en,
   input  logic [NUM_BUTTONS-1:0] button_i,
   output logic [NUM_BUTTONS-1:0] pressed_o,
   output logic                   strobe_o,
   output logic [2:0]             code_o
);

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
   begin : g_param_check
      $error("team_07_button_conditioner: bad parameters");
   end

   logic [NUM_BUTTONS-1:0] level;
   logic [NUM_BUTTONS-1:0] rise;
   logic                   any_rise;
   button_code_t           win;
   logic                   fire;
   button_code_t           fire_code;
   button_code_t           code_d;
   button_code_t           code_q;
   logic                   strobe_q;

   for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
      team_07_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk  (clk),
         .nrst (nrst),
         .en   (en),
         .raw  (button_i[g]),
         .level(level[g]),
         .rise (rise[g])
      );
   end

   assign any_rise = |rise;
   assign win      = first_code(rise);

`ifdef BUTTON_AUTOREPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                         REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);

   logic          rep_active;
   logic          rep_first;
   logic [2:0]    rep_idx;
   logic [RW-1:0] rep_cnt;
   logic          rep_held;
   logic          rep_due;

   assign rep_held  = level[rep_idx];
   assign rep_due   = rep_cnt == (rep_first ? RW'(REPEAT_DELAY - 1)
                                            : RW'(REPEAT_PERIOD - 1));
   assign fire      = en & ~any_rise & rep_active & rep_held & rep_due;
   assign fire_code = button_code_t'(rep_idx + 3'd1);

   // A fresh press always retargets; release or disable drops the tracker.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rep_active <= 1'b0;
         rep_first  <= 1'b0;
         rep_idx    <= '0;
         rep_cnt    <= '0;
      end else if (!en) begin
         rep_active <= 1'b0;
      end else if (any_rise) begin
         rep_active <= 1'b1;
         rep_first  <= 1'b1;
         rep_idx    <= 3'(win) - 3'd1;
         rep_cnt    <= '0;
      end else if (rep_active) begin
         if (!rep_held) begin
            rep_active <= 1'b0;
         end else if (rep_due) begin
            rep_first <= 1'b0;
            rep_cnt   <= '0;
         end else begin
            rep_cnt <= rep_cnt + 1'b1;
         end
      end
   end
`else
   assign fire      = 1'b0;
   assign fire_code = CODE_NONE;
`endif

   always_comb begin
      code_d = CODE_NONE;
      if (any_rise)  code_d = win;
      else if (fire) code_d = fire_code;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         strobe_q <= 1'b0;
         code_q   <= CODE_NONE;
      end else begin
         strobe_q <= any_rise | fire;
         code_q   <= code_d;
      end
   end

   assign pressed_o = level;
   assign strobe_o  = strobe_q;
   assign code_o    = code_q;

endmodule
